// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and RAM-side signals around mem_port_arbiter.
// The slave modport is the arbiter's view; master is the CPU + RAM environment.
interface mem_port_arbiter_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic        inst_ack;
  logic        data_req;
  logic        data_we;
  logic [31:0] data_addr;
  logic [3:0]  data_byte_slct;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_ack;
  logic        mem_ce;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_byte_slct;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        stall_req;

  modport slave (
    input  inst_req, inst_addr, data_req, data_we, data_addr, data_byte_slct,
           data_wdata, mem_rdata,
    output inst_data, inst_ack, data_rdata, data_ack, mem_ce, mem_we, mem_addr,
           mem_byte_slct, mem_wdata, stall_req
  );

  modport master (
    output inst_req, inst_addr, data_req, data_we, data_addr, data_byte_slct,
           data_wdata, mem_rdata,
    input  inst_data, inst_ack, data_rdata, data_ack, mem_ce, mem_we, mem_addr,
           mem_byte_slct, mem_wdata, stall_req
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between instruction fetch and the data port,
// one access at a time, with data priority bounded by a starvation limit.
module mem_port_arbiter #(
  parameter int unsigned MemLatency  = 1,
  parameter int unsigned StarveLimit = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned CntW = 4;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_e;

  typedef struct packed {
    logic        is_data;
    logic        we;
    logic [3:0]  byte_slct;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_e          state_q, state_d;
  logic [CntW-1:0] lat_cnt_q, lat_cnt_d;
  logic [CntW-1:0] starve_cnt_q, starve_cnt_d;
  req_t            req_q, req_d;

  logic [31:0] inst_data_q, inst_data_d;
  logic [31:0] data_rdata_q, data_rdata_d;
  logic        inst_ack_q, inst_ack_d;
  logic        data_ack_q, data_ack_d;
  logic        mem_ce_q, mem_ce_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_byte_slct_q, mem_byte_slct_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic grant_inst, grant_data, last_beat;

  // Data wins ties until fetch has been passed over StarveLimit times in a row.
  assign grant_inst = bus.inst_req &
                      (~bus.data_req | (starve_cnt_q == CntW'(StarveLimit)));
  assign grant_data = bus.data_req & ~grant_inst;
  assign last_beat  = (state_q == ST_ACCESS) && (lat_cnt_q == '0);

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= ST_IDLE;
      lat_cnt_q       <= '0;
      starve_cnt_q    <= '0;
      req_q           <= '0;
      inst_data_q     <= '0;
      data_rdata_q    <= '0;
      inst_ack_q      <= 1'b0;
      data_ack_q      <= 1'b0;
      mem_ce_q        <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_byte_slct_q <= '0;
      mem_wdata_q     <= '0;
    end else begin
      state_q         <= state_d;
      lat_cnt_q       <= lat_cnt_d;
      starve_cnt_q    <= starve_cnt_d;
      req_q           <= req_d;
      inst_data_q     <= inst_data_d;
      data_rdata_q    <= data_rdata_d;
      inst_ack_q      <= inst_ack_d;
      data_ack_q      <= data_ack_d;
      mem_ce_q        <= mem_ce_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_byte_slct_q <= mem_byte_slct_d;
      mem_wdata_q     <= mem_wdata_d;
    end
  end

  // Next state, grant latch, latency and starvation counters.
  always_comb begin
    state_d      = state_q;
    lat_cnt_d    = lat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    req_d        = req_q;
    case (state_q)
      ST_IDLE: begin
        if (!bus.inst_req) starve_cnt_d = '0;
        if (grant_inst) begin
          req_d        = '{is_data: 1'b0, we: 1'b0, byte_slct: 4'hF,
                           addr: bus.inst_addr, wdata: 32'h0};
          starve_cnt_d = '0;
          lat_cnt_d    = CntW'(MemLatency - 1);
          state_d      = ST_ACCESS;
        end else if (grant_data) begin
          req_d     = '{is_data: 1'b1, we: bus.data_we,
                        byte_slct: bus.data_byte_slct,
                        addr: bus.data_addr, wdata: bus.data_wdata};
          if (bus.inst_req && (starve_cnt_q < CntW'(StarveLimit)))
            starve_cnt_d = starve_cnt_q + CntW'(1);
          lat_cnt_d = CntW'(MemLatency - 1);
          state_d   = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (lat_cnt_q == '0) state_d = ST_RESP;
        else                 lat_cnt_d = lat_cnt_q - CntW'(1);
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output next-values, derived from the state being entered.
  always_comb begin
    inst_data_d     = inst_data_q;
    data_rdata_d    = data_rdata_q;
    inst_ack_d      = 1'b0;
    data_ack_d      = 1'b0;
    mem_ce_d        = 1'b0;
    mem_we_d        = 1'b0;
    mem_addr_d      = '0;
    mem_byte_slct_d = '0;
    mem_wdata_d     = '0;
    if (state_d == ST_ACCESS) begin
      mem_ce_d        = 1'b1;
      mem_we_d        = req_d.is_data & req_d.we;
      mem_addr_d      = req_d.addr;
      mem_byte_slct_d = req_d.byte_slct;
      mem_wdata_d     = req_d.wdata;
    end
    if (last_beat) begin
      if (!req_q.is_data)  inst_data_d  = bus.mem_rdata;
      else if (!req_q.we)  data_rdata_d = bus.mem_rdata;
    end
    if (state_d == ST_RESP) begin
      inst_ack_d = ~req_q.is_data;
      data_ack_d = req_q.is_data;
    end
  end

  assign bus.inst_data     = inst_data_q;
  assign bus.data_rdata    = data_rdata_q;
  assign bus.inst_ack      = inst_ack_q;
  assign bus.data_ack      = data_ack_q;
  assign bus.mem_ce        = mem_ce_q;
  assign bus.mem_we        = mem_we_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_byte_slct = mem_byte_slct_q;
  assign bus.mem_wdata     = mem_wdata_q;

  // Stall is combinational so the pipeline freezes in the same cycle as the request.
  assign bus.stall_req = rst & ((bus.inst_req & ~inst_ack_q) |
                                (bus.data_req & ~data_ack_q));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: four instances with different
// latency/starvation settings, each exercised by its own vector group.
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_mis;

  mem_port_arbiter_if if1 ();
  mem_port_arbiter_if if2 ();
  mem_port_arbiter_if if3 ();
  mem_port_arbiter_if if4 ();

  mem_port_arbiter #(.MemLatency(1), .StarveLimit(4)) u_l1 (.clk(clk), .rst(rst), .bus(if1));
  mem_port_arbiter #(.MemLatency(2), .StarveLimit(2)) u_l2 (.clk(clk), .rst(rst), .bus(if2));
  mem_port_arbiter #(.MemLatency(3), .StarveLimit(4)) u_l3 (.clk(clk), .rst(rst), .bus(if3));
  mem_port_arbiter #(.MemLatency(4), .StarveLimit(4)) u_l4 (.clk(clk), .rst(rst), .bus(if4));

  // Real byte-lane RAM behind the latency-1 instance; address-derived data elsewhere.
  logic [31:0] ram [16];
  assign if1.mem_rdata = ram[if1.mem_addr[5:2]];
  assign if2.mem_rdata = if2.mem_addr ^ 32'hA5A5_0000;
  assign if3.mem_rdata = if3.mem_addr ^ 32'hA5A5_0000;
  assign if4.mem_rdata = if4.mem_addr ^ 32'hA5A5_0000;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) ram[i] <= '0;
      ram[1] <= 32'h3401_0011;
    end else if (if1.mem_ce && if1.mem_we) begin
      for (int b = 0; b < 4; b++)
        if (if1.mem_byte_slct[b])
          ram[if1.mem_addr[5:2]][8*b +: 8] <= if1.mem_wdata[8*b +: 8];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all;
    if1.inst_req = 1'b0; if1.inst_addr = '0; if1.data_req = 1'b0; if1.data_we = 1'b0;
    if1.data_addr = '0; if1.data_byte_slct = '0; if1.data_wdata = '0;
    if2.inst_req = 1'b0; if2.inst_addr = '0; if2.data_req = 1'b0; if2.data_we = 1'b0;
    if2.data_addr = '0; if2.data_byte_slct = '0; if2.data_wdata = '0;
    if3.inst_req = 1'b0; if3.inst_addr = '0; if3.data_req = 1'b0; if3.data_we = 1'b0;
    if3.data_addr = '0; if3.data_byte_slct = '0; if3.data_wdata = '0;
    if4.inst_req = 1'b0; if4.inst_addr = '0; if4.data_req = 1'b0; if4.data_we = 1'b0;
    if4.data_addr = '0; if4.data_byte_slct = '0; if4.data_wdata = '0;
  endtask

  int d_at, i_at, both, stall_bad, nack, first_at, last_at, ce_cnt, addr_bad, ghost, busy;
  logic [5:0] seq;

  initial begin
    n_cmp = 0;
    n_mis = 0;
    rst   = 1'b0;
    idle_all();
    if1.inst_req = 1'b1;
    #12;
    // Power-on reset: everything zero, stall masked even with a pending request.
    check_eq("por_inst_ack",  32'(if1.inst_ack),  32'h0);
    check_eq("por_data_ack",  32'(if1.data_ack),  32'h0);
    check_eq("por_mem_ce",    32'(if1.mem_ce),    32'h0);
    check_eq("por_mem_addr",  if1.mem_addr,       32'h0);
    check_eq("por_inst_data", if1.inst_data,      32'h0);
    check_eq("por_stall",     32'(if1.stall_req), 32'h0);
    if1.inst_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick(); tick();

    // Single fetch, latency 1.
    if1.inst_req = 1'b1; if1.inst_addr = 32'h0000_0004;
    tick();
    check_eq("fetch_ce",    32'(if1.mem_ce),        32'h1);
    check_eq("fetch_addr",  if1.mem_addr,           32'h4);
    check_eq("fetch_bs",    32'(if1.mem_byte_slct), 32'hF);
    check_eq("fetch_we",    32'(if1.mem_we),        32'h0);
    check_eq("fetch_stall", 32'(if1.stall_req),     32'h1);
    tick();
    check_eq("fetch_ack",    32'(if1.inst_ack), 32'h1);
    check_eq("fetch_data",   if1.inst_data,     32'h3401_0011);
    check_eq("fetch_ce_off", 32'(if1.mem_ce),   32'h0);
    check_eq("fetch_dack",   32'(if1.data_ack), 32'h0);
    check_eq("fetch_stall0", 32'(if1.stall_req), 32'h0);
    if1.inst_req = 1'b0;
    tick();
    check_eq("fetch_pulse", 32'(if1.inst_ack), 32'h0);

    // Preload data_rdata with a read so the write's "unchanged" is observable.
    if1.data_req = 1'b1; if1.data_we = 1'b0; if1.data_addr = 32'h4; if1.data_byte_slct = 4'hF;
    tick(); tick();
    check_eq("rd0_ack",  32'(if1.data_ack), 32'h1);
    check_eq("rd0_data", if1.data_rdata,    32'h3401_0011);
    if1.data_req = 1'b0;
    tick();

    // Partial write of 0xDEADBEEF to 0x10 on the low two lanes.
    if1.data_req = 1'b1; if1.data_we = 1'b1; if1.data_addr = 32'h10;
    if1.data_byte_slct = 4'b0011; if1.data_wdata = 32'hDEAD_BEEF;
    tick();
    check_eq("wr_ce",    32'(if1.mem_ce),        32'h1);
    check_eq("wr_we",    32'(if1.mem_we),        32'h1);
    check_eq("wr_bs",    32'(if1.mem_byte_slct), 32'h3);
    check_eq("wr_addr",  if1.mem_addr,           32'h10);
    check_eq("wr_wdata", if1.mem_wdata,          32'hDEAD_BEEF);
    tick();
    check_eq("wr_ack",   32'(if1.data_ack), 32'h1);
    check_eq("wr_rdata", if1.data_rdata,    32'h3401_0011);
    if1.data_req = 1'b0;
    tick();

    if1.data_req = 1'b1; if1.data_we = 1'b0; if1.data_addr = 32'h10; if1.data_byte_slct = 4'hF;
    tick();
    check_eq("rd_we", 32'(if1.mem_we), 32'h0);
    tick();
    check_eq("rd_ack",  32'(if1.data_ack), 32'h1);
    check_eq("rd_data", if1.data_rdata,    32'h0000_BEEF);
    if1.data_req = 1'b0;
    tick();

    // Simultaneous requests, latency 2: data acks 2 edges after grant, fetch 6.
    d_at = -1; i_at = -1; both = 0; stall_bad = 0;
    if2.inst_req = 1'b1; if2.inst_addr = 32'h100;
    if2.data_req = 1'b1; if2.data_we = 1'b0; if2.data_addr = 32'h200; if2.data_byte_slct = 4'hF;
    for (int rel = 0; rel < 16; rel++) begin
      tick();
      if (if2.inst_ack && if2.data_ack) both++;
      if (i_at < 0 && !if2.inst_ack && !if2.stall_req) stall_bad++;
      if (if2.inst_ack && if2.stall_req) stall_bad++;
      if (if2.data_ack && d_at < 0) begin d_at = rel; if2.data_req = 1'b0; end
      if (if2.inst_ack && i_at < 0) begin i_at = rel; if2.inst_req = 1'b0; end
    end
    check_eq("sim_data_ack_at", 32'(d_at),      32'd2);
    check_eq("sim_inst_ack_at", 32'(i_at),      32'd6);
    check_eq("sim_coincide",    32'(both),      32'd0);
    check_eq("sim_stall",       32'(stall_bad), 32'd0);
    check_eq("sim_drdata",      if2.data_rdata, 32'hA5A5_0200);
    check_eq("sim_idata",       if2.inst_data,  32'hA5A5_0100);

    // Starvation limit 2 with both requests held: D D I D D I, one ack per 4 cycles.
    seq = '0; nack = 0; first_at = -1; last_at = -1; both = 0;
    if2.inst_req = 1'b1; if2.data_req = 1'b1;
    for (int rel = 0; rel < 40; rel++) begin
      tick();
      if (if2.inst_ack && if2.data_ack) both++;
      if (nack < 6 && (if2.inst_ack || if2.data_ack)) begin
        seq = {seq[4:0], if2.data_ack};
        if (nack == 0) first_at = rel;
        nack++;
        if (nack == 6) begin
          last_at = rel;
          if2.inst_req = 1'b0; if2.data_req = 1'b0;
        end
      end
    end
    check_eq("stv_order",    32'(seq),      32'b110110);
    check_eq("stv_count",    32'(nack),     32'd6);
    check_eq("stv_first_at", 32'(first_at), 32'd2);
    check_eq("stv_last_at",  32'(last_at),  32'd22);
    check_eq("stv_coincide", 32'(both),     32'd0);

    // Latency 4 read; address changed after grant must not reach the RAM.
    ce_cnt = 0; addr_bad = 0; d_at = -1;
    if4.data_req = 1'b1; if4.data_we = 1'b0; if4.data_addr = 32'h40; if4.data_byte_slct = 4'hF;
    for (int rel = 0; rel < 12; rel++) begin
      tick();
      if (if4.mem_ce) begin
        ce_cnt++;
        if (if4.mem_addr != 32'h40) addr_bad++;
      end
      if (rel == 1) if4.data_addr = 32'h80;
      if (if4.data_ack && d_at < 0) begin d_at = rel; if4.data_req = 1'b0; end
    end
    check_eq("sw_ce_cycles", 32'(ce_cnt),    32'd4);
    check_eq("sw_addr_held", 32'(addr_bad),  32'd0);
    check_eq("sw_ack_at",    32'(d_at),      32'd4);
    check_eq("sw_rdata",     if4.data_rdata, 32'hA5A5_0040);

    // Reset mid-access at latency 3: outputs clear at once, dropped access never acks.
    if3.data_req = 1'b1; if3.data_we = 1'b1; if3.data_addr = 32'h30;
    if3.data_byte_slct = 4'hF; if3.data_wdata = 32'h1234_5678;
    tick(); tick();
    check_eq("rst_pre_ce", 32'(if3.mem_ce), 32'h1);
    check_eq("rst_pre_we", 32'(if3.mem_we), 32'h1);
    rst = 1'b0;
    #1;
    check_eq("rst_ce",    32'(if3.mem_ce),        32'h0);
    check_eq("rst_we",    32'(if3.mem_we),        32'h0);
    check_eq("rst_addr",  if3.mem_addr,           32'h0);
    check_eq("rst_wdata", if3.mem_wdata,          32'h0);
    check_eq("rst_bs",    32'(if3.mem_byte_slct), 32'h0);
    check_eq("rst_stall", 32'(if3.stall_req),     32'h0);
    check_eq("rst_dack",  32'(if3.data_ack),      32'h0);
    if3.data_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    ghost = 0; busy = 0;
    for (int rel = 0; rel < 8; rel++) begin
      tick();
      if (if3.data_ack || if3.inst_ack) ghost++;
      if (if3.mem_ce) busy++;
    end
    check_eq("rst_no_ack", 32'(ghost), 32'd0);
    check_eq("rst_idle",   32'(busy),  32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified RAM between the CPU instruction-fetch port (read-only) and the MEM-stage data port (read/write).
- Serialises requests through a req/ack handshake and holds the memory-side signals for a configurable access latency.
- Raises a stall request while any requester is waiting.
- Sits between the pipeline CPU and the RAM model at SOPC level, replacing the separate ROM path.

Parameters:
- MemLatency, 1, cycles memory-side signals are held per access (legal 1..15).
- StarveLimit, 4, consecutive data grants allowed while inst_req is pending before instruction fetch gets forced priority (legal 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-low.
- inst_req  input  1  instruction fetch request.
- inst_addr  input  32  fetch byte address.
- inst_data  output  32  fetched instruction, valid with inst_ack.
- inst_ack  output  1  one-cycle completion pulse for fetch.
- data_req  input  1  data access request.
- data_we  input  1  1 = write, 0 = read.
- data_addr  input  32  data byte address.
- data_byte_slct  input  4  byte lane enables.
- data_wdata  input  32  write data.
- data_rdata  output  32  read data, valid with data_ack.
- data_ack  output  1  one-cycle completion pulse for data.
- mem_ce  output  1  RAM access enable.
- mem_we  output  1  RAM write enable.
- mem_addr  output  32  RAM address.
- mem_byte_slct  output  4  RAM byte lanes; 4'b1111 for fetches.
- mem_wdata  output  32  RAM write data.
- mem_rdata  input  32  RAM read data (combinational from mem_addr).
- stall_req  output  1  pipeline stall request.

Behaviour:
- Reset (rst=0, async):
  - FSM goes to IDLE; the latency counter and starvation counter clear.
  - All outputs are 0: inst_data, data_rdata, both acks, all mem_* signals and stall_req.
  - An in-flight access is abandoned with no ack; the requester reissues after reset.
- FSM states:
  - IDLE: arbitration is sampled at each rising edge.
    - No request: stay in IDLE.
    - Otherwise latch the winner id plus its addr, we, byte_slct and wdata into internal registers, load the counter with MemLatency-1, and go to ACCESS.
  - ACCESS:
    - mem_ce=1. mem_addr, mem_byte_slct and mem_wdata come from the latched copies. mem_we=1 only for a latched data write.
    - Counter decrements each cycle. At counter==0, capture mem_rdata into inst_data (fetch) or data_rdata (data read), and go to RESP.
    - A data write leaves data_rdata unchanged.
  - RESP:
    - mem_* outputs are 0. The winner's ack is 1 for exactly this cycle.
    - Next state is always IDLE, even if new requests are present.
- Latency: request seen high at edge k completes with ack high during cycle k+MemLatency+1.
  - Sustained throughput is one access per MemLatency+2 cycles.
- Handshake:
  - The requester holds req and all request fields stable until it sees ack.
  - Fields are latched at grant, so changes after the grant do not affect the access.
  - req still high in the cycle after the RESP cycle is treated as a new request.
  - The two acks are never high together.
- Arbitration in IDLE:
  - Only one requester active: it wins.
  - Both active: data wins, unless starve_cnt == StarveLimit, in which case inst wins.
- Starvation counter (4 bits):
  - Increments when data wins while inst_req=1.
  - Clears when inst wins, or when inst_req=0 at an arbitration edge.
  - Saturates at StarveLimit.
- stall_req = (inst_req & ~inst_ack) | (data_req & ~data_ack), combinational. It is 0 during reset.
- Addresses pass through unchanged. No alignment check or fault generation.

Test Plan:
- Reset: rst=0 mid-ACCESS with MemLatency=3 -> all outputs 0 immediately; after rst=1 the FSM is IDLE and no ack is emitted for the dropped request.
- Single fetch: MemLatency=1, inst_req=1, inst_addr=0x00000004, RAM word[1]=0x34010011 -> mem_ce=1 with mem_addr=0x4 and mem_byte_slct=4'b1111 for one cycle; next cycle inst_ack=1 and inst_data=0x34010011.
- Data write then read: write 0xDEADBEEF to 0x10 with byte_slct=4'b0011, then read 0x10 -> write cycle shows mem_we=1 and mem_byte_slct=4'b0011, data_rdata unchanged on its ack; the read returns 0x0000BEEF when prior contents are 0.
- Simultaneous requests: inst_req and data_req both high, MemLatency=2 -> data acked first (ack at k+3), inst acked next (ack at k+7); acks are never coincident; stall_req is 1 until the inst ack.
- Starvation: StarveLimit=2, inst_req held high while data_req is reissued continuously -> exactly 2 data grants, then an inst grant, then the counter resets to 0.
- Latency sweep: MemLatency=4, single data read -> mem_ce high for exactly 4 cycles and data_ack at k+5.
